// File: rtl/reaction_pkg.sv
// Shared widths and types for the reaction-test timing blocks.
package reaction_pkg;

    localparam int CNT_W = 14;

    typedef logic [CNT_W-1:0] ms_t;

    // Saturation value of the ms counter, also the "no best yet" marker.
    localparam ms_t MS_MAX = '1;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_HZ/1000 enabled cycles.
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int DIV   = CLK_HZ / 1000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] TERMINAL = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q;

    assign tick = en & ~clr & (pre_q == TERMINAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else if (clr) begin
            pre_q <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignment for all sequential state avoids evaluation-order races.
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time ms counter with late flag, edge-triggered result capture and
// optional best-time register (enabled by defining REACTION_BEST_TIME_EN).
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int LATE_MS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic time_clr,
    input  logic time_en,
    input  logic rs_en,
    output logic time_late,
    output ms_t  ms_count,
    output ms_t  result_ms,
    output logic result_valid,
    output ms_t  best_ms,
    output logic new_best
);

    logic tick;
    logic capture;
    logic rs_q;
    logic result_valid_q;
    ms_t  ms_count_q;
    ms_t  ms_count_d;
    ms_t  result_ms_q;

    ms_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (time_clr),
        .en  (time_en),
        .tick(tick)
    );

    always_comb begin
        // NOTE: default assignment first so every path drives ms_count_d and no latch is inferred.
        ms_count_d = ms_count_q;
        if (time_clr) begin
            ms_count_d = '0;
        end else if (tick && (ms_count_q != MS_MAX)) begin
            ms_count_d = ms_count_q + ms_t'(1);
        end
    end

    assign capture = rs_en & ~rs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_count_q     <= '0;
            rs_q           <= 1'b0;
            result_ms_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            ms_count_q     <= ms_count_d;
            rs_q           <= rs_en;
            result_valid_q <= capture;
            // Samples the pre-update count, so a coincident tick or clear is not seen.
            if (capture) begin
                result_ms_q <= ms_count_q;
            end
        end
    end

    // Zero check keeps the flag low after a clear even for LATE_MS of 0.
    assign time_late    = (ms_count_q != '0) && (32'(ms_count_q) >= LATE_MS);
    assign ms_count     = ms_count_q;
    assign result_ms    = result_ms_q;
    assign result_valid = result_valid_q;

`ifdef REACTION_BEST_TIME_EN
    ms_t  best_ms_q;
    logic new_best_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            best_ms_q  <= MS_MAX;
            new_best_q <= 1'b0;
        end else begin
            new_best_q <= capture && (ms_count_q < best_ms_q);
            if (capture && (ms_count_q < best_ms_q)) begin
                best_ms_q <= ms_count_q;
            end
        end
    end

    assign best_ms  = best_ms_q;
    assign new_best = new_best_q;
`else
    assign best_ms  = MS_MAX;
    assign new_best = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Randomized and directed bench for reaction_timer against a count-based reference model.
module tb_reaction_timer;
    import reaction_pkg::*;

    localparam int LATE = 5;
    localparam int MAXV = (1 << CNT_W) - 1;
`ifdef REACTION_BEST_TIME_EN
    localparam bit BEST = 1'b1;
`else
    localparam bit BEST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, time_clr, time_en, rs_en;
    logic tl [2];
    logic rv [2];
    logic nb [2];
    ms_t  ms [2];
    ms_t  res [2];
    ms_t  best [2];

    int checks = 0;
    int errors = 0;

    // Reference state: instance 0 has 10 cycles/ms, instance 1 has 1 cycle/ms.
    int div_of [2] = '{10, 1};
    int en_cyc [2];
    int m_ms [2];
    int m_res [2];
    int m_rv [2];
    int m_best [2];
    int m_nb [2];
    int m_rs_prev [2];

    always #5 clk = ~clk;

    reaction_timer #(.CLK_HZ(10_000), .LATE_MS(LATE)) u_dut0 (
        .clk(clk), .rst(rst), .time_clr(time_clr), .time_en(time_en), .rs_en(rs_en),
        .time_late(tl[0]), .ms_count(ms[0]), .result_ms(res[0]), .result_valid(rv[0]),
        .best_ms(best[0]), .new_best(nb[0])
    );

    reaction_timer #(.CLK_HZ(1_000), .LATE_MS(LATE)) u_dut1 (
        .clk(clk), .rst(rst), .time_clr(time_clr), .time_en(time_en), .rs_en(rs_en),
        .time_late(tl[1]), .ms_count(ms[1]), .result_ms(res[1]), .result_valid(rv[1]),
        .best_ms(best[1]), .new_best(nb[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ms_count is simply whole milliseconds of enabled time since the last clear, saturated.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                en_cyc[i] = 0; m_ms[i] = 0; m_res[i] = 0; m_rv[i] = 0;
                m_best[i] = MAXV; m_nb[i] = 0; m_rs_prev[i] = 0;
            end else begin
                int  old_ms;
                bit  cap;
                cap    = rs_en && !m_rs_prev[i];
                old_ms = m_ms[i];
                if (time_clr) en_cyc[i] = 0;
                else if (time_en) en_cyc[i]++;
                m_ms[i] = en_cyc[i] / div_of[i];
                if (m_ms[i] > MAXV) m_ms[i] = MAXV;
                m_rv[i] = cap;
                m_nb[i] = 0;
                if (cap) begin
                    m_res[i] = old_ms;
                    if (BEST && old_ms < m_best[i]) begin
                        m_best[i] = old_ms;
                        m_nb[i]   = 1;
                    end
                end
                m_rs_prev[i] = rs_en;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ms_count[%0d]", i), 32'(ms[i]), m_ms[i]);
            check($sformatf("time_late[%0d]", i), 32'(tl[i]), (m_ms[i] >= LATE && m_ms[i] != 0));
            check($sformatf("result_ms[%0d]", i), 32'(res[i]), m_res[i]);
            check($sformatf("result_valid[%0d]", i), 32'(rv[i]), m_rv[i]);
            check($sformatf("best_ms[%0d]", i), 32'(best[i]), m_best[i]);
            check($sformatf("new_best[%0d]", i), 32'(nb[i]), m_nb[i]);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ms"}, 32'(ms[0]), 0);
        check({tag, "_late"}, 32'(tl[0]), 0);
        check({tag, "_res"}, 32'(res[0]), 0);
        check({tag, "_rv"}, 32'(rv[0]), 0);
        check({tag, "_best"}, 32'(best[0]), MAXV);
        check({tag, "_nb"}, 32'(nb[0]), 0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; time_clr = 1'b0; time_en = 1'b0; rs_en = 1'b0;
        step(2);
        check_reset_values("reset");
        rst = 1'b0;

        // Clear then count 35 enabled cycles -> 3 ms.
        time_clr = 1'b1; step(3);
        time_clr = 1'b0; time_en = 1'b1; step(35);
        check("cnt35_ms", 32'(ms[0]), 3);
        check("cnt35_late", 32'(tl[0]), 0);

        // Late threshold and clear.
        step(14);
        check("pre_late_ms", 32'(ms[0]), 4);
        check("pre_late", 32'(tl[0]), 0);
        step(1);
        check("late_ms", 32'(ms[0]), 5);
        check("late_flag", 32'(tl[0]), 1);
        time_clr = 1'b1; step(1);
        check("clr_ms", 32'(ms[0]), 0);
        check("clr_late", 32'(tl[0]), 0);
        time_clr = 1'b0;

        // Held rs_en gives one capture; count holds while disabled. First capture: 3.
        step(30);
        time_en = 1'b0; rs_en = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (k == 0) begin
                check("cap3_res", 32'(res[0]), 3);
                check("cap3_best", 32'(best[0]), BEST ? 3 : MAXV);
                check("cap3_nb", 32'(nb[0]), BEST ? 1 : 0);
            end
            pulses += int'(rv[0]);
        end
        check("single_pulse", pulses, 1);
        check("held_ms", 32'(ms[0]), 3);
        rs_en = 1'b0; step(1);

        // Capture 2 (new best), then 4 (not a best).
        time_clr = 1'b1; step(1);
        time_clr = 1'b0; time_en = 1'b1; step(20);
        time_en = 1'b0; rs_en = 1'b1; step(1);
        check("cap2_res", 32'(res[0]), 2);
        check("cap2_best", 32'(best[0]), BEST ? 2 : MAXV);
        check("cap2_nb", 32'(nb[0]), BEST ? 1 : 0);
        rs_en = 1'b0; time_clr = 1'b1; step(1);
        time_clr = 1'b0; time_en = 1'b1; step(40);
        time_en = 1'b0; rs_en = 1'b1; step(1);
        check("cap4_res", 32'(res[0]), 4);
        check("cap4_best", 32'(best[0]), BEST ? 2 : MAXV);
        check("cap4_nb", 32'(nb[0]), 0);
        rs_en = 1'b0; step(1);

        // Capture coincident with a tick 3 -> 4.
        time_clr = 1'b1; step(1);
        time_clr = 1'b0; time_en = 1'b1; step(39);
        rs_en = 1'b1; step(1);
        check("tick_cap_res", 32'(res[0]), 3);
        check("tick_cap_ms", 32'(ms[0]), 4);
        rs_en = 1'b0; step(1);

        // Capture coincident with time_clr.
        time_clr = 1'b1; step(1);
        time_clr = 1'b0; step(30);
        rs_en = 1'b1; time_clr = 1'b1; step(1);
        check("clr_cap_res", 32'(res[0]), 3);
        check("clr_cap_ms", 32'(ms[0]), 0);
        rs_en = 1'b0; time_clr = 1'b0; step(1);

        // Randomized traffic, including occasional resets.
        for (int k = 0; k < 800; k++) begin
            time_clr = ($urandom_range(15) == 0);
            time_en  = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) rs_en = ~rs_en;
            rst      = ($urandom_range(199) == 0);
            step(1);
        end
        rst = 1'b0; time_clr = 1'b1; rs_en = 1'b0; step(1);

        // Saturation on the 1 cycle/ms instance.
        time_clr = 1'b0; time_en = 1'b1;
        step(MAXV + 20);
        check("sat_ms", 32'(ms[1]), MAXV);
        check("sat_late", 32'(tl[1]), 1);

        // Reset mid-count with rs_en high: reset values, then capture on release.
        rs_en = 1'b1; rst = 1'b1; step(1);
        check_reset_values("midrst");
        check("midrst_ms1", 32'(ms[1]), 0);
        rst = 1'b0; time_en = 1'b0; step(1);
        check("rel_cap_rv", 32'(rv[0]), 1);
        check("rel_cap_res", 32'(res[0]), 0);
        rs_en = 1'b0; step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
